// File: rtl/sram_ctrl.sv
// sram_ctrl: bridges a 32-bit MEM-stage load/store port to a 16-bit
// asynchronous SRAM. Each word access is split into a low-halfword phase
// (LO) and a high-halfword phase (HI), each lasting WAIT cycles, followed by
// a single DONE cycle in which ready releases the pipeline freeze.
module sram_ctrl #(
   parameter int unsigned BASE_ADDR = 1024,
   parameter int unsigned WAIT      = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rd_en,
   input  logic        wr_en,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        ready,
   output logic [17:0] sram_addr,
   output logic [15:0] sram_dq_out,
   input  logic [15:0] sram_dq_in,
   output logic        sram_dq_oe,
   output logic        sram_we_n
);

   typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

   // Terminal count of the per-phase wait counter.
   localparam logic [3:0] LAST_CNT = 4'(WAIT - 1);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        op_wr_q;
   logic [16:0] word_q;
   logic [31:0] data_q;

   logic        accept;
   logic        cap_lo;
   logic        cap_hi;
   logic        phase_end;
   logic        req;

   // Word index relative to the SRAM window; addresses below BASE_ADDR wrap.
   logic [31:0] offset;
   logic [16:0] word_in;
   logic [14:0] unused_offset_bits;

   assign req                = rd_en | wr_en;
   assign offset             = address - 32'(BASE_ADDR);
   assign word_in            = offset[18:2];
   assign unused_offset_bits = {offset[31:19], offset[1:0]};
   assign phase_end          = (cnt_q == LAST_CNT);

   // State register and phase counter.
   // NOTE: the reset is synchronous, so it lives inside the clocked branch
   // and is only seen at a rising edge; there is no rst in the sensitivity list.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
      end else begin
         // NOTE: non-blocking assignments keep every register updating from
         // the pre-edge values, independent of statement order.
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic and SRAM pin/handshake decode.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves one
      // unassigned, which would otherwise infer a latch.
      state_d     = state_q;
      cnt_d       = cnt_q + 4'd1;
      accept      = 1'b0;
      cap_lo      = 1'b0;
      cap_hi      = 1'b0;
      ready       = 1'b1;
      sram_addr   = 18'd0;
      sram_dq_out = 16'd0;
      sram_dq_oe  = 1'b0;
      sram_we_n   = 1'b1;

      case (state_q)
         IDLE: begin
            // Freeze in the same cycle the request shows up.
            ready = ~req;
            cnt_d = 4'd0;
            if (req) begin
               accept  = 1'b1;
               state_d = LO;
            end
         end
         LO: begin
            ready     = 1'b0;
            sram_addr = {word_q, 1'b0};
            if (op_wr_q) begin
               sram_dq_oe  = 1'b1;
               sram_we_n   = 1'b0;
               sram_dq_out = data_q[15:0];
            end
            if (phase_end) begin
               cap_lo  = ~op_wr_q;
               cnt_d   = 4'd0;
               state_d = HI;
            end
         end
         HI: begin
            ready     = 1'b0;
            sram_addr = {word_q, 1'b1};
            if (op_wr_q) begin
               sram_dq_oe  = 1'b1;
               sram_we_n   = 1'b0;
               sram_dq_out = data_q[31:16];
            end
            if (phase_end) begin
               cap_hi  = ~op_wr_q;
               cnt_d   = 4'd0;
               state_d = DONE;
            end
         end
         DONE: begin
            // One-cycle release of the freeze; any held request is re-seen in IDLE.
            cnt_d   = 4'd0;
            state_d = IDLE;
         end
         default: begin
            cnt_d   = 4'd0;
            state_d = IDLE;
         end
      endcase

      // During reset the pins look idle immediately, so an aborted write
      // cannot keep strobing the SRAM while the state register catches up.
      if (!rst) begin
         ready       = ~req;
         sram_addr   = 18'd0;
         sram_dq_out = 16'd0;
         sram_dq_oe  = 1'b0;
         sram_we_n   = 1'b1;
         cap_lo      = 1'b0;
         cap_hi      = 1'b0;
      end
   end

   // Request latch and read-data capture; writes never touch read_data.
   always_ff @(posedge clk) begin
      if (!rst) begin
         op_wr_q   <= 1'b0;
         word_q    <= 17'd0;
         data_q    <= 32'd0;
         read_data <= 32'd0;
      end else begin
         if (accept) begin
            op_wr_q <= wr_en;
            word_q  <= word_in;
            data_q  <= write_data;
         end
         if (cap_lo) begin
            read_data[15:0] <= sram_dq_in;
         end
         if (cap_hi) begin
            read_data[31:16] <= sram_dq_in;
         end
      end
   end

endmodule
